// File: rtl/npc_arch_state_if.sv
// Bundle of the architectural-state block's data ports: PC, register file and lookup mux.
// The core/decoder side drives through master; npc_arch_state consumes through slave.
interface npc_arch_state_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_KEY     = 4,
  parameter int KEY_LEN    = 7
);
  localparam int LUT_WIDTH = NR_KEY * (KEY_LEN + DATA_WIDTH);

  logic [DATA_WIDTH-1:0] pc_din;
  logic                  pc_wen;
  logic [DATA_WIDTH-1:0] pc;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [ADDR_WIDTH-1:0] rf_rs1addr;
  logic [ADDR_WIDTH-1:0] rf_rs2addr;
  logic [DATA_WIDTH-1:0] rf_rs1data;
  logic [DATA_WIDTH-1:0] rf_rs2data;

  logic [KEY_LEN-1:0]    mux_key;
  logic [LUT_WIDTH-1:0]  mux_lut;
  logic [DATA_WIDTH-1:0] mux_default;
  logic [DATA_WIDTH-1:0] mux_out;
  logic                  mux_hit;

  modport master (
    output pc_din, pc_wen,
    output rf_wen, rf_waddr, rf_wdata, rf_rs1addr, rf_rs2addr,
    output mux_key, mux_lut, mux_default,
    input  pc, rf_rs1data, rf_rs2data, mux_out, mux_hit
  );

  modport slave (
    input  pc_din, pc_wen,
    input  rf_wen, rf_waddr, rf_wdata, rf_rs1addr, rf_rs2addr,
    input  mux_key, mux_lut, mux_default,
    output pc, rf_rs1data, rf_rs2data, mux_out, mux_hit
  );
endinterface

// File: rtl/npc_arch_state.sv
// Architectural state of the single-cycle NPC core: PC register, 2R/1W register file
// with x0 hardwired to zero, and a generic {key,value} lookup mux with default.
module npc_arch_state #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h8000_0000,
  parameter int                    NR_KEY     = 4,
  parameter int                    KEY_LEN    = 7
) (
  input  logic clk,
  input  logic rst,
  npc_arch_state_if.slave bus
);

  localparam int NR_REGS   = 2 ** ADDR_WIDTH;
  localparam int ENTRY_LEN = KEY_LEN + DATA_WIDTH;

  // ------------------------------------------------------------------
  // Program counter
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (bus.pc_wen) begin
      pc_d = bus.pc_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc = pc_q;

  // ------------------------------------------------------------------
  // Register file
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rf_q [NR_REGS];
  logic [DATA_WIDTH-1:0] rf_d [NR_REGS];
  logic [NR_REGS-1:0]    rf_wsel;

  // Entry 0 never gets a write strobe, so its storage stays at its reset value of 0.
  assign rf_wsel[0] = 1'b0;
  for (genvar gi = 1; gi < NR_REGS; gi++) begin : g_rf_wsel
    assign rf_wsel[gi] = bus.rf_wen && (bus.rf_waddr == ADDR_WIDTH'(gi));
  end

  always_comb begin
    for (int i = 0; i < NR_REGS; i++) begin
      rf_d[i] = rf_wsel[i] ? bus.rf_wdata : rf_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR_REGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Reads come straight from storage: a same-cycle write is not visible until the edge.
  assign bus.rf_rs1data = (bus.rf_rs1addr == '0) ? '0 : rf_q[bus.rf_rs1addr];
  assign bus.rf_rs2data = (bus.rf_rs2addr == '0) ? '0 : rf_q[bus.rf_rs2addr];

  // ------------------------------------------------------------------
  // Key/value lookup mux
  // ------------------------------------------------------------------
  logic [NR_KEY-1:0][KEY_LEN-1:0]    lut_key;
  logic [NR_KEY-1:0][DATA_WIDTH-1:0] lut_val;
  logic [NR_KEY-1:0]                 lut_match;
  logic [DATA_WIDTH-1:0]             mux_out_d;

  for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_lut_entry
    assign lut_key[gi]   = bus.mux_lut[gi*ENTRY_LEN + DATA_WIDTH +: KEY_LEN];
    assign lut_val[gi]   = bus.mux_lut[gi*ENTRY_LEN +: DATA_WIDTH];
    assign lut_match[gi] = (lut_key[gi] == bus.mux_key);
  end

  // Ascending scan so the highest-index (first-listed) duplicate overrides lower ones.
  always_comb begin
    mux_out_d = bus.mux_default;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut_match[i]) begin
        mux_out_d = lut_val[i];
      end
    end
  end

  assign bus.mux_out = mux_out_d;
  assign bus.mux_hit = |lut_match;

endmodule

// File: tb/tb_npc_arch_state.sv
// Directed and random checks of npc_arch_state: reset, PC, register file and lookup mux.
module tb_npc_arch_state;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NK = 4;
  localparam int KL = 7;
  localparam int LW = NK * (KL + DW);

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] pc_exp;

  npc_arch_state_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_KEY(NK), .KEY_LEN(KL)) bus ();

  npc_arch_state #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .PC_RESET  (32'h8000_0000),
    .NR_KEY    (NK),
    .KEY_LEN   (KL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc_din      = '0;
    bus.pc_wen      = 1'b0;
    bus.rf_wen      = 1'b0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    bus.rf_rs1addr  = '0;
    bus.rf_rs2addr  = '0;
    bus.mux_key     = '0;
    bus.mux_lut     = '0;
    bus.mux_default = '0;
  endtask

  initial begin
    logic [LW-1:0] lut;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    idle_inputs();

    // Reset state, and writes ignored while reset is held
    repeat (2) step();
    bus.rf_rs1addr = 5'd5;
    #1;
    check("rst_pc", bus.pc, 32'h8000_0000);
    check("rst_x5", bus.rf_rs1data, 32'h0);
    bus.pc_din   = 32'h0000_1234;
    bus.pc_wen   = 1'b1;
    bus.rf_wen   = 1'b1;
    bus.rf_waddr = 5'd7;
    bus.rf_wdata = 32'hFFFF_FFFF;
    bus.rf_rs2addr = 5'd7;
    step();
    check("rst_pc_hold", bus.pc, 32'h8000_0000);
    check("rst_x7_ignored", bus.rf_rs2data, 32'h0);
    $display("txn reset: pc=0x%08h x7=0x%08h", bus.pc, bus.rf_rs2data);
    idle_inputs();
    rst = 1'b0;

    // Test 1: asynchronous reset mid-cycle
    bus.pc_din   = 32'h8000_0010;
    bus.pc_wen   = 1'b1;
    bus.rf_wen   = 1'b1;
    bus.rf_waddr = 5'd5;
    bus.rf_wdata = 32'h0000_1234;
    step();
    idle_inputs();
    bus.rf_rs1addr = 5'd5;
    #1;
    check("t1_pc_loaded", bus.pc, 32'h8000_0010);
    check("t1_x5_written", bus.rf_rs1data, 32'h0000_1234);
    #2;
    rst = 1'b1;
    #1;
    check("t1_async_pc", bus.pc, 32'h8000_0000);
    check("t1_async_x5", bus.rf_rs1data, 32'h0);
    $display("txn async reset: pc=0x%08h x5=0x%08h", bus.pc, bus.rf_rs1data);
    step();
    rst = 1'b0;

    // Test 2: PC increments then holds
    pc_exp = 32'h8000_0000;
    for (int k = 0; k < 3; k++) begin
      bus.pc_din = pc_exp + 32'd4;
      bus.pc_wen = 1'b1;
      step();
      pc_exp = pc_exp + 32'd4;
      check("t2_pc_inc", bus.pc, pc_exp);
      $display("txn pc step %0d: pc=0x%08h", k, bus.pc);
    end
    bus.pc_wen = 1'b0;
    bus.pc_din = 32'hDEAD_BEEF;
    repeat (2) step();
    check("t2_pc_hold", bus.pc, 32'h8000_000C);
    $display("txn pc hold: pc=0x%08h", bus.pc);

    // Test 3: x0 discard, x31 write, no read bypass
    bus.rf_wen     = 1'b1;
    bus.rf_waddr   = 5'd0;
    bus.rf_wdata   = 32'hDEAD_BEEF;
    bus.rf_rs1addr = 5'd0;
    step();
    check("t3_x0_zero", bus.rf_rs1data, 32'h0);
    bus.rf_waddr   = 5'd31;
    bus.rf_wdata   = 32'hA5A5_A5A5;
    bus.rf_rs1addr = 5'd31;
    bus.rf_rs2addr = 5'd31;
    #1;
    check("t3_x31_prewrite", bus.rf_rs2data, 32'h0);
    step();
    check("t3_x31_rs2", bus.rf_rs2data, 32'hA5A5_A5A5);
    check("t3_x31_rs1", bus.rf_rs1data, 32'hA5A5_A5A5);
    bus.rf_wdata = 32'h1111_1111;
    #1;
    check("t3_no_bypass", bus.rf_rs1data, 32'hA5A5_A5A5);
    step();
    check("t3_x31_rewrite", bus.rf_rs1data, 32'h1111_1111);
    bus.rf_wen = 1'b0;
    $display("txn regfile: x0=0x%08h x31=0x%08h", 32'h0, bus.rf_rs1data);

    // Test 4: lookup mux hit/miss, entries 0 and NR_KEY-1 included
    lut = {7'h67, 32'd4, 7'h6F, 32'd3, 7'h17, 32'd2, 7'h13, 32'd1};
    bus.mux_lut     = lut;
    bus.mux_default = 32'hFFFF_FFFF;
    bus.mux_key     = 7'h6F;
    #1;
    check("t4_out_6f", bus.mux_out, 32'd3);
    check("t4_hit_6f", 32'(bus.mux_hit), 32'd1);
    bus.mux_key = 7'h13;
    #1;
    check("t4_out_13", bus.mux_out, 32'd1);
    bus.mux_key = 7'h67;
    #1;
    check("t4_out_67", bus.mux_out, 32'd4);
    bus.mux_key = 7'h33;
    #1;
    check("t4_out_miss", bus.mux_out, 32'hFFFF_FFFF);
    check("t4_hit_miss", 32'(bus.mux_hit), 32'd0);
    $display("txn mux: key=0x33 out=0x%08h hit=%0b", bus.mux_out, bus.mux_hit);

    // Test 5: duplicate key, highest-index entry wins
    lut = {7'h03, 32'h0000_00AA, 7'h10, 32'd1, 7'h11, 32'd2, 7'h03, 32'h0000_0055};
    bus.mux_lut = lut;
    bus.mux_key = 7'h03;
    #1;
    check("t5_dup_out", bus.mux_out, 32'h0000_00AA);
    check("t5_dup_hit", 32'(bus.mux_hit), 32'd1);
    $display("txn mux dup: out=0x%08h", bus.mux_out);

    // Test 6: random regression against a reference model
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    for (int t = 0; t < 1000; t++) begin
      bus.rf_wen     = ($urandom_range(0, 3) != 0);
      bus.rf_waddr   = AW'($urandom_range(0, 31));
      bus.rf_wdata   = $urandom;
      bus.rf_rs1addr = AW'($urandom_range(0, 31));
      bus.rf_rs2addr = AW'($urandom_range(0, 31));
      #1;
      check("t6_rs1", bus.rf_rs1data, model[bus.rf_rs1addr]);
      check("t6_rs2", bus.rf_rs2data, model[bus.rf_rs2addr]);
      $display("txn rnd %0d: we=%0b wa=%0d wd=0x%08h rs1=%0d:0x%08h rs2=%0d:0x%08h",
               t, bus.rf_wen, bus.rf_waddr, bus.rf_wdata,
               bus.rf_rs1addr, bus.rf_rs1data, bus.rf_rs2addr, bus.rf_rs2data);
      step();
      if (bus.rf_wen && bus.rf_waddr != '0) model[bus.rf_waddr] = bus.rf_wdata;
    end
    bus.rf_wen     = 1'b0;
    bus.rf_rs1addr = '0;
    #1;
    check("t6_x0_final", bus.rf_rs1data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
